// File: rtl/tank_pkg.sv
// ---------------------------------------------------------------------------
// tank_pkg
// Shared constants and the sequencer state type for the delay-line tank
// gate sequencer. Imported by tank_timing_ctr and tank_gate_seq.
//   DIGITS_PER_MINOR : digit pulses per minor cycle (one word time)
//   MINORS_PER_TANK  : word positions circulating in one tank
//   NUM_RACKS        : tank distribution units, one gate bit each
// ---------------------------------------------------------------------------
package tank_pkg;

  localparam int DIGITS_PER_MINOR = 18;
  localparam int MINORS_PER_TANK  = 16;
  localparam int NUM_RACKS        = 4;
  localparam int DIGIT_W          = 5;
  localparam int MINOR_W          = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GATE,
    DONE
  } tank_state_e;

endpackage

// File: rtl/tank_timing_ctr.sv
// ---------------------------------------------------------------------------
// tank_timing_ctr
// Free-running digit/minor-cycle position counters.
// Ports:
//   clk       : digit-pulse clock
//   rst       : synchronous active-high reset, clears both counters
//   digit_cnt : digit position 0..17 within the current minor cycle
//   minor_cnt : minor-cycle position 0..15 within the tank
//   wrap      : high during digit 17, i.e. the last digit of a minor cycle
// ---------------------------------------------------------------------------
module tank_timing_ctr
  import tank_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [DIGIT_W-1:0] digit_cnt,
  output logic [MINOR_W-1:0] minor_cnt,
  output logic               wrap
);

  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [MINOR_W-1:0] minor_q, minor_d;

  assign wrap      = (digit_q == DIGIT_W'(DIGITS_PER_MINOR - 1));
  assign digit_cnt = digit_q;
  assign minor_cnt = minor_q;

  // Digit counter wraps after the last digit; the minor counter advances on
  // that same wrap and rolls 15 -> 0 on its own since it spans the tank.
  always_comb begin
    digit_d = digit_q + DIGIT_W'(1);
    minor_d = minor_q;
    if (wrap) begin
      digit_d = '0;
      minor_d = minor_q + MINOR_W'(1);
    end
  end

  // Counter registers with synchronous reset back to position zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
      minor_q <= '0;
    end else begin
      digit_q <= digit_d;
      minor_q <= minor_d;
    end
  end

endmodule

// File: rtl/tank_gate_seq.sv
// ---------------------------------------------------------------------------
// tank_gate_seq
// Accepts one tank transfer request at a time, waits for the requested word
// position to come round, and opens exactly one in/out gate for one minor
// cycle (or two with long words), then pulses done.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid / req_ready     : request handshake (ready only when idle)
//   req_tank                  : [4:3] rack, [2] half (1=up), [1] f8, [0] f7
//   req_pos                   : target minor-cycle word position
//   req_write                 : 1 = in gate (store), 0 = out gate (read)
//   req_long                  : long-word transfer (macro build only)
//   rack_{down,up}_{in,out}   : one-hot per-rack gate vectors
//   f7_pos, f8_pos            : latched tank address bits while busy
//   done                      : one-cycle pulse after the gate closes
//   digit_cnt, minor_cnt      : current timing position
// Build option: define TANK_LONG_WORD_EN to honour req_long (pos[0] cleared,
// gate held for two consecutive minor cycles). Otherwise req_long is ignored.
// ---------------------------------------------------------------------------
module tank_gate_seq
  import tank_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4:0]           req_tank,
  input  logic [MINOR_W-1:0]   req_pos,
  input  logic                 req_write,
  input  logic                 req_long,
  output logic [NUM_RACKS-1:0] rack_down_in,
  output logic [NUM_RACKS-1:0] rack_up_in,
  output logic [NUM_RACKS-1:0] rack_down_out,
  output logic [NUM_RACKS-1:0] rack_up_out,
  output logic                 f7_pos,
  output logic                 f8_pos,
  output logic                 done,
  output logic [DIGIT_W-1:0]   digit_cnt,
  output logic [MINOR_W-1:0]   minor_cnt
);

  tank_state_e        state_q, state_d;
  logic [4:0]         tank_q, tank_d;
  logic [MINOR_W-1:0] pos_q, pos_d;
  logic               write_q, write_d;
  logic               long_q, long_d;
  logic               second_q, second_d;

  logic               wrap;
  logic [MINOR_W-1:0] nextMinor;
  logic [MINOR_W-1:0] effPos;
  logic               longIn;
  logic [NUM_RACKS-1:0] rackHot;

  tank_timing_ctr u_timing (
    .clk       (clk),
    .rst       (rst),
    .digit_cnt (digit_cnt),
    .minor_cnt (minor_cnt),
    .wrap      (wrap)
  );

  assign nextMinor = minor_cnt + MINOR_W'(1);

  // Long words occupy an even/odd pair of minor cycles, so the start
  // position is forced even and the gate is held through both.
`ifdef TANK_LONG_WORD_EN
  assign longIn = req_long;
  assign effPos = req_long ? {req_pos[MINOR_W-1:1], 1'b0} : req_pos;
`else
  logic unusedLong;
  assign unusedLong = req_long;
  assign longIn     = 1'b0;
  assign effPos     = req_pos;
`endif

  // Next-state logic. The gate opens on the edge after digit 17 of the minor
  // cycle preceding the target, so a request accepted exactly on that digit
  // goes straight to GATE instead of waiting a full tank revolution.
  always_comb begin
    state_d  = state_q;
    tank_d   = tank_q;
    pos_d    = pos_q;
    write_d  = write_q;
    long_d   = long_q;
    second_d = second_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          tank_d   = req_tank;
          pos_d    = effPos;
          write_d  = req_write;
          long_d   = longIn;
          second_d = 1'b0;
          state_d  = (wrap && (nextMinor == effPos)) ? GATE : WAIT;
        end
      end
      WAIT: begin
        if (wrap && (nextMinor == pos_q)) begin
          second_d = 1'b0;
          state_d  = GATE;
        end
      end
      GATE: begin
        if (wrap) begin
          if (long_q && !second_q) begin
            second_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decoded outputs are functions of registered state only, so a reset edge
  // drops every gate and status output immediately.
  always_comb begin
    rackHot       = NUM_RACKS'(1) << tank_q[4:3];
    rack_down_in  = '0;
    rack_up_in    = '0;
    rack_down_out = '0;
    rack_up_out   = '0;
    req_ready     = (state_q == IDLE);
    done          = (state_q == DONE);
    f7_pos        = 1'b0;
    f8_pos        = 1'b0;
    if (state_q != IDLE) begin
      f7_pos = tank_q[0];
      f8_pos = tank_q[1];
    end
    if (state_q == GATE) begin
      case ({write_q, tank_q[2]})
        2'b11:   rack_up_in    = rackHot;
        2'b10:   rack_down_in  = rackHot;
        2'b01:   rack_up_out   = rackHot;
        default: rack_down_out = rackHot;
      endcase
    end
  end

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tank_q   <= '0;
      pos_q    <= '0;
      write_q  <= 1'b0;
      long_q   <= 1'b0;
      second_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tank_q   <= tank_d;
      pos_q    <= pos_d;
      write_q  <= write_d;
      long_q   <= long_d;
      second_q <= second_d;
    end
  end

endmodule

// File: tb/tb_tank_gate_seq.sv
// ---------------------------------------------------------------------------
// tb_tank_gate_seq
// Randomised scoreboard bench for tank_gate_seq. The reference model works
// in absolute clock time since the last reset: position = time mod 18 /
// (time / 18) mod 16, and a transfer opens at the first digit-0 of the
// target minor cycle after acceptance. Compile with TANK_LONG_WORD_EN to
// check the long-word build.
// ---------------------------------------------------------------------------
module tb_tank_gate_seq;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_tank;
  logic [3:0] req_pos;
  logic       req_write;
  logic       req_long;
  logic [3:0] rack_down_in, rack_up_in, rack_down_out, rack_up_out;
  logic       f7_pos, f8_pos, done;
  logic [4:0] digit_cnt;
  logic [3:0] minor_cnt;

  typedef struct {
    int          tOpen;
    int          dur;
    logic [15:0] gateWord;
    logic        f7;
    logic        f8;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   tc = 0;
  int   idleAt = 0;
  bit   modelValid = 0;

  tank_gate_seq dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_tank      (req_tank),
    .req_pos       (req_pos),
    .req_write     (req_write),
    .req_long      (req_long),
    .rack_down_in  (rack_down_in),
    .rack_up_in    (rack_up_in),
    .rack_down_out (rack_down_out),
    .rack_up_out   (rack_up_out),
    .f7_pos        (f7_pos),
    .f8_pos        (f8_pos),
    .done          (done),
    .digit_cnt     (digit_cnt),
    .minor_cnt     (minor_cnt)
  );

  // Free-running digit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench time since the last reset edge, matching what the counters show.
  always @(posedge clk) begin
    if (rst) tc <= 0;
    else     tc <= tc + 1;
  end

  // Single comparison point; every check funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (tc=%0d)", name, act, expv, tc);
    end
  endtask

  // Issue one request at the current negedge, predict its response and push
  // it onto the scoreboard; returns one negedge later with req_valid low.
  task automatic applyStimulus(input logic [4:0] tank, input logic [3:0] pos,
                               input logic wr, input logic lng, output int tOpen);
    exp_t e;
    int   pEff;
    int   dur;
    logic [3:0] hot;
    req_valid = 1'b1;
    req_tank  = tank;
    req_pos   = pos;
    req_write = wr;
    req_long  = lng;
    pEff = int'(pos);
    dur  = 18;
`ifdef TANK_LONG_WORD_EN
    if (lng) begin
      pEff = pEff & 14;
      dur  = 36;
    end
`endif
    tOpen = tc + 1;
    while (!((tOpen % 18) == 0 && ((tOpen / 18) % 16) == pEff)) tOpen++;
    hot = 4'b0001 << tank[4:3];
    case ({wr, tank[2]})
      2'b10:   e.gateWord = {hot, 12'h000};
      2'b11:   e.gateWord = {4'h0, hot, 8'h00};
      2'b00:   e.gateWord = {8'h00, hot, 4'h0};
      default: e.gateWord = {12'h000, hot};
    endcase
    e.tOpen = tOpen;
    e.dur   = dur;
    e.f7    = tank[0];
    e.f8    = tank[1];
    expQ.push_back(e);
    idleAt = tOpen + dur + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait until the model says the DUT is idle, optionally waving random
  // requests at it meanwhile (they must all be ignored).
  task automatic waitIdle(input bit junk);
    while (tc < idleAt) begin
      if (junk) begin
        req_valid = 1'($urandom_range(0, 1));
        req_tank  = 5'($urandom);
        req_pos   = 4'($urandom);
        req_write = 1'($urandom);
        req_long  = 1'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each edge, checks the timing
  // position and idle outputs directly, and matches each completed gate
  // window against the head of the scoreboard on the done pulse.
  initial begin : monitor
    bit          inGate;
    int          obsOpen;
    int          obsLen;
    logic [15:0] obsWord;
    bit          obsBad;
    logic [15:0] gw;
    exp_t        e;
    inGate = 0;
    obsOpen = 0;
    obsLen = 0;
    obsWord = '0;
    obsBad = 0;
    forever begin
      @(posedge clk);
      #1;
      gw = {rack_down_in, rack_up_in, rack_down_out, rack_up_out};
      if (rst) begin
        modelValid = 1;
        inGate = 0;
        expQ.delete();
        checkOutput("reset_gates", 32'(gw), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_ready", 32'(req_ready), 32'h1);
        checkOutput("reset_digit", 32'(digit_cnt), 32'h0);
        checkOutput("reset_minor", 32'(minor_cnt), 32'h0);
        checkOutput("reset_f7f8", 32'({f8_pos, f7_pos}), 32'h0);
      end else if (modelValid) begin
        checkOutput("digit_cnt", 32'(digit_cnt), 32'(tc % 18));
        checkOutput("minor_cnt", 32'(minor_cnt), 32'((tc / 18) % 16));
        checkOutput("req_ready", 32'(req_ready), 32'(tc >= idleAt));
        if (tc >= idleAt) begin
          checkOutput("idle_gates", 32'(gw), 32'h0);
          checkOutput("idle_f7f8", 32'({f8_pos, f7_pos}), 32'h0);
        end
        if (gw != 16'h0) begin
          if (!inGate) begin
            inGate  = 1;
            obsOpen = tc;
            obsWord = gw;
            obsLen  = 0;
            obsBad  = 0;
          end
          obsLen++;
          if (gw != obsWord) obsBad = 1;
        end else begin
          inGate = 0;
        end
        if (done) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 32'h1, 32'h0);
          end else begin
            e = expQ.pop_front();
            checkOutput("gate_open_time", 32'(obsOpen), 32'(e.tOpen));
            checkOutput("gate_length", 32'(obsLen), 32'(e.dur));
            checkOutput("gate_vector", 32'(obsWord), 32'(e.gateWord));
            checkOutput("gate_stable", 32'(obsBad), 32'h0);
            checkOutput("done_time", 32'(tc), 32'(e.tOpen + e.dur));
            checkOutput("f7_f8_held", 32'({f8_pos, f7_pos}), 32'({e.f8, e.f7}));
          end
          obsOpen = -1;
          obsLen  = 0;
        end else if (expQ.size() != 0 && tc > expQ[0].tOpen + expQ[0].dur + 2) begin
          checkOutput("done_timeout", 32'h0, 32'h1);
          void'(expQ.pop_front());
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomised traffic with junk held on
  // the request inputs while busy, then a long-word request and an abort.
  initial begin : driver
    int t;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_tank  = '0;
    req_pos   = '0;
    req_write = 1'b0;
    req_long  = 1'b0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    idleAt = 0;

    while (tc != 4) @(negedge clk);
    applyStimulus(5'b01110, 4'd3, 1'b0, 1'b0, t);

    waitIdle(0);
    while ((tc % 288) != 287) @(negedge clk);
    applyStimulus(5'b11001, 4'd0, 1'b1, 1'b0, t);

    for (int i = 0; i < 30; i++) begin
      waitIdle(1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(5'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), t);
    end

    waitIdle(1);
    applyStimulus(5'($urandom), 4'd7, 1'b0, 1'b1, t);

    waitIdle(0);
    applyStimulus(5'b10101, 4'($urandom), 1'b1, 1'b0, t);
    while (tc != t + 4) @(negedge clk);
    rst    = 1'b1;
    idleAt = 0;
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(5'b00011, 4'($urandom), 1'b0, 1'b0, t);
    waitIdle(0);
    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
